// File: rtl/key_debounce3.sv
// key_debounce3 -- three independent push-button conditioners.
// Each channel: two-flop synchroniser, stability-counter debounce, registered
// press pulse. Outputs feed the full-adder stage KEY1/KEY2/KEY3 inputs.
// Optional build macro: KEY_DEBOUNCE_TOGGLE_EN -- KEY*_DB becomes a toggle
// register that flips on each accepted press instead of the debounced level.
module key_debounce3 #(
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = 20,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY1,
  input  logic KEY2,
  input  logic KEY3,
  output logic KEY1_DB,
  output logic KEY2_DB,
  output logic KEY3_DB,
  output logic KEY1_P,
  output logic KEY2_P,
  output logic KEY3_P
);

  // Terminal count: the edge that sees cnt at this value with s2 still
  // differing from stable is the accept edge.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  // Raw-polarity levels for "released" and "pressed".
  localparam logic REL_LVL = ACTIVE_LOW;
  localparam logic PRS_LVL = ~ACTIVE_LOW;

  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       stable;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       accept;
  logic [2:0]       accept_press;
  logic [2:0]       press_p;
  logic [2:0]       db_lvl;

  assign raw = {KEY3, KEY2, KEY1};

  // Two-flop synchroniser; reset parks both stages at the released level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= {3{REL_LVL}};
      s2 <= {3{REL_LVL}};
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept detection: s2 has differed from stable for DB_CYCLES edges.
  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept       = '0;
    accept_press = '0;
    for (int i = 0; i < 3; i++) begin
      accept[i]       = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      accept_press[i] = accept[i] && (s2[i] == PRS_LVL);
    end
  end

  // Per-channel stability counter, accepted level and registered press pulse.
  // NOTE: the cnt array is per-channel control state, not storage, so every
  // entry is reset explicitly; reset discards any in-progress debounce.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      stable  <= {3{REL_LVL}};
      press_p <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          // Any return to the accepted level restarts the count: no partial credit.
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      press_p <= accept_press;
    end
  end

`ifdef KEY_DEBOUNCE_TOGGLE_EN
  logic [2:0] tog;

  // Toggle register: flips on each accepted press, release accepts ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tog <= '0;
    end else begin
      tog <= tog ^ accept_press;
    end
  end

  assign db_lvl = tog;
`else
  // Logical level: XOR with a constant keeps the output a plain flop output.
  assign db_lvl = stable ^ {3{ACTIVE_LOW}};
`endif

  assign KEY1_DB = db_lvl[0];
  assign KEY2_DB = db_lvl[1];
  assign KEY3_DB = db_lvl[2];
  assign KEY1_P  = press_p[0];
  assign KEY2_P  = press_p[1];
  assign KEY3_P  = press_p[2];

endmodule

// File: tb/tb_key_debounce3.sv
// Scoreboard bench for key_debounce3 with DB_CYCLES=4, CNT_W=3, ACTIVE_LOW=1.
// Stimulus pushes the expected {DB,P} vector for each future edge; a monitor
// pops and compares on every falling edge. Build with KEY_DEBOUNCE_TOGGLE_EN
// to exercise toggle mode instead of the level-mode scenarios.
module tb_key_debounce3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] keys;
  logic       KEY1_DB, KEY2_DB, KEY3_DB;
  logic       KEY1_P, KEY2_P, KEY3_P;

  key_debounce3 #(
    .DB_CYCLES (4),
    .CNT_W     (3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .KEY1   (keys[0]),
    .KEY2   (keys[1]),
    .KEY3   (keys[2]),
    .KEY1_DB(KEY1_DB),
    .KEY2_DB(KEY2_DB),
    .KEY3_DB(KEY3_DB),
    .KEY1_P (KEY1_P),
    .KEY2_P (KEY2_P),
    .KEY3_P (KEY3_P)
  );

  always #5 CLK = ~CLK;

  // Rising-edge number; outputs seen at the following falling edge belong to it.
  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_no;
    logic [2:0] db;
    logic [2:0] p;
    bit         add;
    string      tag;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Full-adder truth table indexed by {KEY3,KEY2,KEY1}.
  logic [7:0] sum_tbl   = 8'b1001_0110;
  logic [7:0] carry_tbl = 8'b1110_1000;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic expect_span(input int from, input int to, input logic [2:0] db,
                             input logic [2:0] p, input bit add, input string tag);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.edge_no = k;
      e.db      = db;
      e.p       = p;
      e.add     = add;
      e.tag     = tag;
      expq.push_back(e);
    end
  endtask

  // Drive raw for n edges (n >= 6); DB changes 6 edges after this falling edge.
  task automatic phase(input logic [2:0] raw, input int n, input logic [2:0] db_old,
                       input logic [2:0] db_new, input logic [2:0] p_acc,
                       input bit add, input string tag);
    int e0;
    e0 = edge_cnt;
    expect_span(e0 + 1, e0 + 5, db_old, 3'b000, add, tag);
    expect_span(e0 + 6, e0 + 6, db_new, p_acc, add, tag);
    expect_span(e0 + 7, e0 + n, db_new, 3'b000, add, tag);
    keys = raw;
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: compare every expectation due at this edge.
  always @(negedge CLK) begin : monitor
    exp_t       e;
    logic [2:0] db_now;
    logic [2:0] p_now;
    db_now = {KEY3_DB, KEY2_DB, KEY1_DB};
    p_now  = {KEY3_P, KEY2_P, KEY1_P};
    while (expq.size() > 0 && expq[0].edge_no <= edge_cnt) begin
      e = expq.pop_front();
      if (e.edge_no < edge_cnt) begin
        check({e.tag, " stale"}, 8'(edge_cnt), 8'(e.edge_no));
      end else begin
        check({e.tag, " db"}, {5'b0, db_now}, {5'b0, e.db});
        check({e.tag, " p"}, {5'b0, p_now}, {5'b0, e.p});
        if (e.add) begin
          check({e.tag, " sum"}, {7'b0, ^db_now}, {7'b0, sum_tbl[e.db]});
          check({e.tag, " carry"},
                {7'b0, (db_now[0] & db_now[1]) | (db_now[2] & (db_now[0] ^ db_now[1]))},
                {7'b0, carry_tbl[e.db]});
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int e0;
    logic [2:0] prev;

    // Reset with keys released: outputs 0 from the first reset edge.
    RST  = 1'b1;
    keys = 3'b111;
    expect_span(1, 2, 3'b000, 3'b000, 1'b0, "reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    phase(3'b111, 8, 3'b000, 3'b000, 3'b000, 1'b0, "idle");

`ifdef KEY_DEBOUNCE_TOGGLE_EN
    // Two press/release cycles on KEY1: toggle on, hold, toggle off.
    phase(3'b110, 10, 3'b000, 3'b001, 3'b001, 1'b0, "tog press1");
    phase(3'b111, 10, 3'b001, 3'b001, 3'b000, 1'b0, "tog release1");
    phase(3'b110, 10, 3'b001, 3'b000, 3'b001, 1'b0, "tog press2");
    phase(3'b111, 10, 3'b000, 3'b000, 3'b000, 1'b0, "tog release2");
`else
    // Clean KEY1 press then release (release accept gives no pulse).
    phase(3'b110, 12, 3'b000, 3'b001, 3'b001, 1'b0, "press1");
    phase(3'b111, 10, 3'b001, 3'b000, 3'b000, 1'b0, "release1");

    // KEY2 bounce: low 3, high 1, then held low. Counter reaches 3 during the
    // bounce but the return to high restarts it; accept 5 edges after e0+5.
    e0 = edge_cnt;
    expect_span(e0 + 1, e0 + 9, 3'b000, 3'b000, 1'b0, "bounce");
    expect_span(e0 + 10, e0 + 10, 3'b010, 3'b010, 1'b0, "bounce accept");
    expect_span(e0 + 11, e0 + 15, 3'b010, 3'b000, 1'b0, "bounce hold");
    keys = 3'b101;
    repeat (3) @(negedge CLK);
    keys = 3'b111;
    repeat (1) @(negedge CLK);
    keys = 3'b101;
    repeat (11) @(negedge CLK);
    phase(3'b111, 10, 3'b010, 3'b000, 3'b000, 1'b0, "bounce release");

    // All eight combinations, checking levels, pulses and the downstream adder.
    prev = 3'b000;
    for (int c = 0; c < 8; c++) begin
      phase(~3'(c), 10, prev, 3'(c), 3'(c) & ~prev, 1'b1, $sformatf("combo%0d", c));
      prev = 3'(c);
    end
    phase(3'b111, 10, 3'b111, 3'b000, 3'b000, 1'b0, "combo release");

    // KEY3 low 3 edges, reset for one edge, KEY3 stays low. First post-reset
    // sampling edge is e0+5, so the accept lands on e0+10.
    e0 = edge_cnt;
    expect_span(e0 + 1, e0 + 9, 3'b000, 3'b000, 1'b0, "rst midcount");
    expect_span(e0 + 10, e0 + 10, 3'b100, 3'b100, 1'b0, "rst midcount accept");
    expect_span(e0 + 11, e0 + 15, 3'b100, 3'b000, 1'b0, "rst midcount hold");
    keys = 3'b011;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (11) @(negedge CLK);
    phase(3'b111, 10, 3'b100, 3'b000, 3'b000, 1'b0, "rst midcount release");
`endif

    repeat (3) @(negedge CLK);
    check("scoreboard drained", 8'(expq.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
